cmutex_split2_pmp: RTL

//  Clocked counterpart of the PMP 2-to-1 mutex merge: takes one merged drive/free channel and routes each

---
 rtl/cmutex_split2_pmp_pkg.sv | 15 +
 rtl/cmutex_split2_pmp_req_fifo.sv | 48 ++++
 rtl/cmutex_split2_pmp.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cmutex_split2_pmp_pkg.sv
// Shared encodings for the PMP request splitter: consumer select values,
// per-consumer state encoding and the completion counter width.
package cmutex_split2_pmp_pkg;

    localparam logic SEL_C0 = 1'b0;
    localparam logic SEL_C1 = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } consState_e;

    localparam int FREE_CNT_W = 3;

endpackage

// File: rtl/cmutex_split2_pmp_req_fifo.sv
// In-order request buffer for the splitter; head is read combinationally
// from registered storage, so a push becomes visible one cycle later.
module pmp_req_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wrPtr;
    logic [AW:0]  rdPtr;
    logic [W-1:0] mem [DEPTH];

    // Extra pointer MSB distinguishes full from empty when low bits match.
    assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign empty = (wrPtr == rdPtr);
    assign rdata = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (push && !full) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop && !empty) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wrPtr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/cmutex_split2_pmp.sv
// Routes a merged drive/free request channel to two consumers in strict order
// and returns one upstream free pulse per completed request.
//   state   | meaning
//   ST_IDLE | consumer can accept a dispatch
//   ST_BUSY | one request in flight, waiting for its free
module cmutex_split2_pmp
    import cmutex_split2_pmp_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_drive,
    input  logic          i_sel,
    input  logic [DW-1:0] i_data,
    output logic          o_free,
    output logic          o_full,
    output logic          o_drive0,
    output logic [DW-1:0] o_data0,
    input  logic          i_free0,
    output logic          o_drive1,
    output logic [DW-1:0] o_data1,
    input  logic          i_free1,
    output logic          o_ovf,
    output logic          o_spur
);

    logic [DW:0]           fifoRdata;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  push;
    logic                  pop;
    logic                  headSel;
    logic [DW-1:0]         headData;
    consState_e            state0, state0Next;
    consState_e            state1, state1Next;
    logic                  disp0, disp1;
    logic                  free0Ok, free1Ok;
    logic [FREE_CNT_W-1:0] freeCnt;
    logic [FREE_CNT_W-1:0] freeSum;

    assign push = i_drive && !fifoFull;

    pmp_req_fifo #(
        .W     (DW + 1),
        .DEPTH (DEPTH)
    ) uReqFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({i_sel, i_data}),
        .rdata (fifoRdata),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    assign {headSel, headData} = fifoRdata;
    assign o_full  = fifoFull;
    assign free0Ok = i_free0 && (state0 == ST_BUSY);
    assign free1Ok = i_free1 && (state1 == ST_BUSY);
    assign pop     = disp0 || disp1;

    // Includes this cycle's frees so o_free follows a free by one cycle.
    assign freeSum = freeCnt + FREE_CNT_W'(free0Ok) + FREE_CNT_W'(free1Ok);

    always_comb begin
        disp0      = 1'b0;
        disp1      = 1'b0;
        state0Next = state0;
        state1Next = state1;
        if (!fifoEmpty) begin
            if (headSel == SEL_C0 && state0 == ST_IDLE) begin
                disp0 = 1'b1;
            end else if (headSel == SEL_C1 && state1 == ST_IDLE) begin
                disp1 = 1'b1;
            end
        end
        if (disp0) begin
            state0Next = ST_BUSY;
        end else if (free0Ok) begin
            state0Next = ST_IDLE;
        end
        if (disp1) begin
            state1Next = ST_BUSY;
        end else if (free1Ok) begin
            state1Next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state0   <= ST_IDLE;
            state1   <= ST_IDLE;
            freeCnt  <= '0;
            o_free   <= 1'b0;
            o_drive0 <= 1'b0;
            o_drive1 <= 1'b0;
            o_data0  <= '0;
            o_data1  <= '0;
            o_ovf    <= 1'b0;
            o_spur   <= 1'b0;
        end else begin
            state0   <= state0Next;
            state1   <= state1Next;
            o_free   <= (freeSum != '0);
            freeCnt  <= freeSum - FREE_CNT_W'(freeSum != '0);
            o_drive0 <= disp0;
            o_drive1 <= disp1;
            if (disp0) begin
                o_data0 <= headData;
            end
            if (disp1) begin
                o_data1 <= headData;
            end
            o_ovf  <= o_ovf || (i_drive && fifoFull);
            o_spur <= o_spur || (i_free0 && state0 == ST_IDLE)
                             || (i_free1 && state1 == ST_IDLE);
        end
    end

endmodule
